uart_msg_streamer: RTL
======================

Name: uart_msg_streamer

Overview:
- Parametrised successor to the fixed-string UART demo sender.
- Transmits a RAM-held message, then an uppercase hex sequence number, then CR LF, over an integrated 8N1 transmitter.
- Transmission runs in periodic mode (timer driven) or triggered mode (`i_trig` pulse).
- Sits between board top-level logic (message writes, triggers) and the USB-UART pin.

Parameters:
- CLK_FREQ, 25_000_000: input clock frequency in Hz.
- BAUD, 115200: line rate. Divisor DIV = CLK_FREQ/BAUD, integer-truncated; DIV must be >= 2.
- MAX_LEN, 32: message RAM depth in bytes. AW = clog2(MAX_LEN).
- HEX_DIGITS, 2: number of hex digits of the sequence counter appended to each message. 0 omits the suffix; legal range 0..8.
- PERIOD, 25_000_000: idle gap in clocks between messages in periodic mode. Must be >= 1.
- TRIG_MODE, 0: 0 = periodic, 1 = triggered.

Ports:
- i_Clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_trig  in  1  start request; used in triggered mode only.
- i_wr_en  in  1  message RAM write strobe.
- i_wr_addr  in  AW  message RAM write address.
- i_wr_data  in  8  message RAM write byte.
- i_msg_len  in  AW+1  number of message bytes to send. Sampled at message start; values > MAX_LEN are clamped to MAX_LEN.
- o_UART_TX  out  1  serial line; idle high.
- o_busy  out  1  high from message start through the last stop bit of LF.
- o_done  out  1  one-cycle pulse after the LF stop bit completes.
- o_seq  out  max(HEX_DIGITS*4,1)  count of messages completed since reset.

Behaviour:
- Reset values: o_UART_TX=1, o_busy=0, o_done=0, o_seq=0, period counter=0, state=IDLE. RAM contents are not reset.
- Reset mid-frame: o_UART_TX returns high on the next edge. No partial frame resumes after reset.
- Message RAM:
  - Single write port, one byte per cycle.
  - Writes are allowed at any time. A byte takes effect if written before its LOAD cycle.
  - Out-of-range addresses are ignored.
- Frame format:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly DIV clocks, so one frame is 10*DIV clocks.
  - Consecutive bytes are back-to-back with no idle gap.
- Byte sequence per message:
  - RAM[0..L-1], where L = clamped length latched at start.
  - Then HEX_DIGITS characters of o_seq, most significant nibble first, using '0'-'9' and 'A'-'F'.
  - Then 0x0D, then 0x0A.
  - L=0 sends only the hex digits and CR LF.
- States: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD for the next byte | DONE) -> IDLE.
  - LOAD: selects the byte and takes 1 cycle.
  - START, DATA, STOP: each bit lasts DIV cycles; DATA covers 8 bits.
  - DONE: 1 cycle. Pulses o_done, increments o_seq (wraps modulo 2^(4*HEX_DIGITS)), clears the period counter.
- Inter-byte gap: the LOAD cycle is absorbed into the last STOP clock, so start bits are spaced exactly 10*DIV clocks apart.
- Start condition, periodic mode:
  - In IDLE the period counter increments each cycle.
  - When it reaches PERIOD-1, the block starts. The first message begins PERIOD cycles after reset release.
- Start condition, triggered mode:
  - i_trig sampled high in IDLE starts a message.
  - i_trig while o_busy is ignored and not queued.
  - Simultaneous i_trig and DONE is ignored.
- Start timing (trigger seen at edge N):
  - o_busy=1 and i_msg_len latched at N+1.
  - o_UART_TX=0 (start bit) at N+2.
  - o_busy falls with the o_done pulse.
- The hex digit value is taken from o_seq before the increment, so the first message carries "00".

Test Plan:
- Bench parameters: CLK_FREQ=1_000_000, BAUD=250_000 (DIV=4), MAX_LEN=8, HEX_DIGITS=2, PERIOD=50, for all scenarios below.
- Triggered, RAM="Hi", len=2, pulse i_trig -> bytes 0x48 0x69 0x30 0x30 0x0D 0x0A; each start bit 40 clocks apart; o_done once; o_seq=1.
- Triggered, 17 messages -> the 17th message's hex suffix is "10"; o_seq=0x11. With HEX_DIGITS=1 and 16 messages, o_seq wraps to 0.
- Periodic, len=0 -> first start bit 51 clocks after reset release; message is "00\r\n"; the next start bit comes 51 clocks after the o_done pulse.
- i_msg_len=12 with MAX_LEN=8 -> exactly 8 RAM bytes sent. i_trig pulsed during a message -> no extra message.
- Assert rst during DATA of byte 1 -> o_UART_TX=1 on the next edge; o_busy=0; o_seq=0; no further activity until a new trigger.
- Overwrite RAM[1] while byte 0 is transmitting -> the new value is sent. Overwrite RAM[0] during the same message -> no effect until the next message.

Source files
------------

// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: sends a RAM-held message, an uppercase hex sequence number and CR LF
// over an integrated 8N1 transmitter, either periodically or on an i_trig pulse.
module uart_msg_streamer #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int MAX_LEN    = 32,
    parameter int HEX_DIGITS = 2,
    parameter int PERIOD     = 25_000_000,
    parameter int TRIG_MODE  = 0,
    localparam int AW = $clog2(MAX_LEN),
    localparam int SW = HEX_DIGITS > 0 ? HEX_DIGITS * 4 : 1
) (
    input  logic          i_Clk,
    input  logic          rst,
    input  logic          i_trig,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW:0]   i_msg_len,
    output logic          o_UART_TX,
    output logic          o_busy,
    output logic          o_done,
    output logic [SW-1:0] o_seq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int DW  = $clog2(DIV);
    localparam int CW  = $clog2(PERIOD + 1);
    localparam int IW  = $clog2(MAX_LEN + HEX_DIGITS + 3);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_ram [2**AW];
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic [IW-1:0] r_idx;
    logic [AW:0]   r_len;
    logic [SW-1:0] r_seq;
    logic          r_tx;
    logic          w_start, w_tick, w_last;
    logic [IW-1:0] w_rel;
    logic [3:0]    w_nib;
    logic [7:0]    w_hex, w_byte;

    assign w_start = TRIG_MODE != 0 ? i_trig : r_cnt == CW'(PERIOD - 1);
    assign w_tick  = r_div == DW'(DIV - 1);
    assign w_last  = r_idx == IW'(r_len) + IW'(HEX_DIGITS + 2);
    // Bytes past the message are indexed relative to its end: hex digits, then CR, then LF.
    assign w_rel   = r_idx - IW'(r_len);
    assign w_nib   = 4'(36'(r_seq) >> (4 * (HEX_DIGITS - 1 - int'(w_rel))));
    assign w_hex   = w_nib < 4'd10 ? 8'h30 + 8'(w_nib) : 8'h37 + 8'(w_nib);
    assign w_byte  = r_idx < IW'(r_len) ? r_ram[r_idx[AW-1:0]] :
                     w_rel < IW'(HEX_DIGITS) ? w_hex :
                     w_rel == IW'(HEX_DIGITS) ? 8'h0D : 8'h0A;

    assign o_UART_TX = r_tx;
    assign o_busy    = r_state != IDLE && r_state != DONE;
    assign o_done    = r_state == DONE;
    assign o_seq     = r_seq;

    always_ff @(posedge i_Clk)
        if (i_wr_en)
            r_ram[i_wr_addr] <= i_wr_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? LOAD : IDLE;
            LOAD:    w_next = START;
            START:   w_next = w_tick ? DATA : START;
            DATA:    w_next = w_tick && r_bit == 3'd7 ? STOP : DATA;
            STOP:    w_next = w_tick ? (w_last ? DONE : START) : STOP;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_seq   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_div   <= r_state inside {START, DATA, STOP} && !w_tick ? r_div + 1'b1 : '0;
            case (r_state)
                IDLE: begin
                    r_cnt <= w_start || TRIG_MODE != 0 ? r_cnt : r_cnt + 1'b1;
                    if (w_start) begin
                        r_len <= i_msg_len > (AW+1)'(MAX_LEN) ? (AW+1)'(MAX_LEN) : i_msg_len;
                        r_idx <= '0;
                    end
                end
                LOAD: begin
                    r_sh  <= w_byte;
                    r_idx <= r_idx + 1'b1;
                    r_tx  <= 1'b0;
                end
                START: begin
                    r_bit <= '0;
                    if (w_tick)
                        r_tx <= r_sh[0];
                end
                DATA:
                    if (w_tick) begin
                        r_bit <= r_bit + 1'b1;
                        r_sh  <= r_sh >> 1;
                        r_tx  <= r_bit == 3'd7 ? 1'b1 : r_sh[1];
                    end
                // The last stop clock doubles as the next byte's load so start bits stay 10*DIV apart.
                STOP:
                    if (w_tick && !w_last) begin
                        r_sh  <= w_byte;
                        r_idx <= r_idx + 1'b1;
                        r_tx  <= 1'b0;
                    end
                DONE: begin
                    r_seq <= r_seq + 1'b1;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
